arb_grant_mux: RTL
==================

Name: arb_grant_mux

Overview:
- Downstream stage of the 8-way rotating-priority arbiter.
- Consumes the arbiter's registered one-hot grant vector and selects the granted requester's data word. It queues the word with its source index in a small FIFO and presents it to a shared sink over a valid/ready handshake.
- Returns a per-requester acknowledge so each requester knows when to drop its request.
- Exports a FIFO-full stall and an error flag for illegal (multi-hot) grants.

Parameters:
- N_REQ, 8, number of requesters; must match the arbiter width.
- DATA_W, 32, width of each requester's data word.
- DEPTH, 4, output FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the saturating rejected-grant counter.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- gnt  input  N_REQ  one-hot or zero grant vector from the arbiter
- req_data  input  N_REQ*DATA_W  requester data; slice i = bits [i*DATA_W +: DATA_W]
- ack  output  N_REQ  combinational; ack[i] high in the cycle requester i's word is accepted
- stall  output  1  registered; high while the FIFO is full
- out_valid  output  1  FIFO not empty
- out_ready  input  1  sink ready
- out_data  output  DATA_W  head-of-FIFO data word
- out_src  output  $clog2(N_REQ)  head-of-FIFO source index
- err_multi  output  1  sticky; set when gnt is multi-hot
- rej_cnt  output  CNT_W  saturating count of grants rejected because the FIFO was full

Behaviour:
- Reset (asynchronous, rst=1):
  - FIFO empty, pointers and count cleared.
  - out_valid=0, out_data=0, out_src=0, stall=0, err_multi=0, rej_cnt=0.
  - ack is 0 because gnt is gated by an internal "not in reset" condition.
  - Reset asserted mid-operation discards all queued entries immediately; no ack is issued during reset.
- Grant classification, each cycle:
  - zero: gnt==0.
  - legal: exactly one bit set.
  - multi: two or more bits set.
- accept = legal & ~full, where full is taken from the registered FIFO count.
- A push is rejected when full even if a pop happens in the same cycle. There is no full-bypass path.
- On accept:
  - ack = gnt in the same cycle.
  - At the clock edge, {index(gnt), req_data slice} is written to the tail. Latency from gnt to out_valid is 1 cycle if the FIFO was empty.
- legal & full:
  - ack=0, nothing written.
  - rej_cnt increments, saturating at 2^CNT_W-1.
  - The requester keeps its request asserted and the arbiter regrants it later.
- multi:
  - ack=0, nothing written, rej_cnt unchanged.
  - err_multi set at the edge and held until reset.
- Pop: out_valid & out_ready advances the head at the edge. out_data and out_src hold stable while out_valid=1 and out_ready=0.
- Push and pop in the same cycle when neither empty nor full: count unchanged, both pointers advance.
- Push into an empty FIFO: the new entry appears on the outputs the next cycle. There is no combinational gnt-to-out path.
- Pointer wrap-around at DEPTH-1 goes to 0. Count range is 0..DEPTH, with full = (count==DEPTH).
- stall is registered and equals the next-state full flag. The arbiter may gate req with ~stall.
- When out_valid=0, out_data and out_src show the last head or reset value; the sink must ignore them.

Decomposition:
- Package arb_pkg holds:
  - N_REQ_DEFAULT=8 and the IDX_W derivation.
  - function onehot_to_idx (priority-free OR-reduction encoder).
  - function is_onehot.
- One sub-module: arb_out_fifo. It is a synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count, the same asynchronous active-high reset, and register-based storage.
- The top level holds gnt classification, the data mux, ack, the error flag and the counter.

Test Plan:
- Reset, then gnt=8'b0000_0100 with slice2=32'hCAFE0002 and out_ready=1 → ack=8'b0000_0100 in the same cycle; next cycle out_valid=1, out_data=32'hCAFE0002, out_src=2; popped the following cycle.
- out_ready=0 with grants to requesters 0,1,2,3 on consecutive cycles → four acks, stall=1 after the 4th push; a 5th grant to requester 5 gives ack=0 and rej_cnt=1. Then out_ready=1 → outputs in order with src 0,1,2,3.
- Full FIFO with out_ready=1 and gnt to requester 7 in the same cycle → push rejected, ack=0, rej_cnt increments, count drops to 3, stall=0 next cycle.
- gnt=8'b0001_0001 → ack=0, no push, err_multi=1 next cycle and held through later legal traffic; rej_cnt unchanged.
- rst pulsed asynchronously mid-cycle with 3 entries queued → out_valid, stall, err_multi and rej_cnt all 0 immediately; a grant after release is accepted normally.
- Force rej_cnt to saturation (CNT_W=4 build, 20 rejected grants) → rej_cnt holds 15.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter grant path.
// Grant decoding is priority-free so a multi-hot grant never silently picks a winner.
package arb_pkg;

  localparam int N_REQ_DEFAULT = 8;
  localparam int IDX_W         = $clog2(N_REQ_DEFAULT);

  // Helpers operate on a fixed wide vector; callers zero-extend their grant.
  localparam int MAX_REQ   = 64;
  localparam int MAX_IDX_W = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    GNT_ZERO  = 2'd0,
    GNT_LEGAL = 2'd1,
    GNT_MULTI = 2'd2
  } gnt_class_e;

  // OR-reduction encoder: exact only for one-hot inputs.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (vec[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [MAX_REQ-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_REQ'(1))) == '0);
  endfunction

endpackage

// File: rtl/arb_out_fifo.sv
// Register-based synchronous FIFO feeding the shared sink.
// Push when full and pop when empty are ignored; storage is cleared on reset.
module arb_out_fifo
  import arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arb_grant_mux.sv
// Downstream of the rotating-priority arbiter: muxes the granted word into the
// output FIFO, acknowledges the requester, and flags stalls and illegal grants.
module arb_grant_mux
  import arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEFAULT,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          gnt,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic                      stall,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(N_REQ)-1:0]  out_src,
  output logic                      err_multi,
  output logic [CNT_W-1:0]          rej_cnt
);

  localparam int SRC_W = $clog2(N_REQ);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int FW    = SRC_W + DATA_W;

  logic [MAX_REQ-1:0]   gnt_ext;
  logic [MAX_IDX_W-1:0] idx_full;
  gnt_class_e           gnt_class;
  logic [SRC_W-1:0]     src_sel;
  logic [DATA_W-1:0]    data_sel;
  logic                 accept;
  logic                 reject_full;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [CW-1:0]        count_nxt;
  logic [FW-1:0]        fifo_rdata;

  always_comb begin
    gnt_ext             = '0;
    gnt_ext[N_REQ-1:0]  = gnt;
  end

  always_comb begin
    gnt_class = GNT_ZERO;
    if (gnt_ext == '0)          gnt_class = GNT_ZERO;
    else if (is_onehot(gnt_ext)) gnt_class = GNT_LEGAL;
    else                        gnt_class = GNT_MULTI;
  end

  assign idx_full = onehot_to_idx(gnt_ext);
  assign src_sel  = idx_full[SRC_W-1:0];

  // AND-OR mux; only meaningful for a legal grant, which is all we ever push.
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) data_sel = data_sel | req_data[i*DATA_W +: DATA_W];
    end
  end

  // Full is the registered count, so a same-cycle pop never frees room for a push.
  assign accept      = (gnt_class == GNT_LEGAL) & ~fifo_full & ~rst;
  assign reject_full = (gnt_class == GNT_LEGAL) & fifo_full;
  assign ack         = accept ? gnt : '0;
  assign pop         = ~fifo_empty & out_ready;

  arb_out_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata ({src_sel, data_sel}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign out_src   = fifo_rdata[FW-1 -: SRC_W];
  assign out_data  = fifo_rdata[DATA_W-1:0];

  always_comb begin
    count_nxt = fifo_count;
    if (accept) count_nxt = count_nxt + CW'(1);
    if (pop)    count_nxt = count_nxt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall     <= 1'b0;
      err_multi <= 1'b0;
      rej_cnt   <= '0;
    end else begin
      stall <= (count_nxt == CW'(DEPTH));
      if (gnt_class == GNT_MULTI) err_multi <= 1'b1;
      if (reject_full && (rej_cnt != '1)) rej_cnt <= rej_cnt + CNT_W'(1);
    end
  end

endmodule
